// File: rtl/gpio_in.sv
// ---------------------------------------------------------------------------
// GpioIn : 32-bit GPIO input peripheral for the picorv32 native memory bus.
//
// Each pin is brought into the clock domain through a two-flop synchronizer.
// A third stage keeps the previous synchronized value so that rising and
// falling edges can be detected. Edges are latched into sticky STATUS bits,
// and each edge type has its own enable mask. Software clears a STATUS bit
// by writing 1 to it. irq is the OR of all STATUS bits.
//
// Register map (word index = mem_addr[3:2]):
//   0 DATA    (RO)   synchronized pin levels
//   1 RISE_EN (RW)   per-pin rising-edge enable, byte-lane writable
//   2 FALL_EN (RW)   per-pin falling-edge enable, byte-lane writable
//   3 STATUS  (RW1C) latched edge events
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   synchronous, active-low reset
//   enable     in   address-decode select from the system bus decoder
//   mem_valid  in   bus request strobe
//   mem_ready  out  transfer acknowledge, gated by enable for the wire-OR bus
//   mem_instr  in   instruction-fetch flag, not used by this block
//   mem_wstrb  in   byte-lane write strobes, all zero means a read
//   mem_wdata  in   write data, little-endian byte lanes
//   mem_addr   in   byte address, only bits 3:2 are decoded
//   mem_rdata  out  read data, forced to zero when not selected
//   pins       in   asynchronous external input pins
//   irq        out  level interrupt request
// ---------------------------------------------------------------------------
module gpio_in (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_instr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   input  logic [31:0] pins,
   output logic        irq
);

   logic [31:0] s1_q;
   logic [31:0] s2_q;
   logic [31:0] prev_q;
   logic [31:0] riseEn_q;
   logic [31:0] riseEn_d;
   logic [31:0] fallEn_q;
   logic [31:0] fallEn_d;
   logic [31:0] status_q;
   logic [31:0] status_d;
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;
   logic        rdy_q;
   logic        rdy_d;

   logic        accept;
   logic        isWrite;
   logic [31:0] laneMask;
   logic [31:0] setEvents;
   logic [31:0] clearMask;
   logic [31:0] regValue;

   // Inputs that the bus carries but this block never looks at.
   logic        unusedBusBits;
   assign unusedBusBits = ^{mem_instr, mem_addr[31:4], mem_addr[1:0]};

   // Bus handshake decode. A new transfer is only taken while no acknowledge
   // is outstanding, which inserts one wait state and prevents back-to-back
   // acceptance. The write strobes are widened into a per-bit lane mask.
   always_comb begin
      accept   = mem_valid & enable & ~rdy_q;
      isWrite  = |mem_wstrb;
      laneMask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                  {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
   end

   // Edge detection on the synchronized pins, qualified by the enables as
   // they stand before this edge, so an enable write only affects later
   // events.
   always_comb begin
      setEvents = ((s2_q & ~prev_q) & riseEn_q) | ((~s2_q & prev_q) & fallEn_q);
   end

   // Read multiplexer. STATUS is read from the register, so a read returns
   // the value before any set that lands on the same edge.
   always_comb begin
      regValue = 32'h0;
      case (mem_addr[3:2])
         2'd0: regValue = s2_q;
         2'd1: regValue = riseEn_q;
         2'd2: regValue = fallEn_q;
         2'd3: regValue = status_q;
      endcase
   end

   // Next-state for the software-visible registers. Enable writes merge new
   // data only into strobed byte lanes. STATUS clears first and then ORs in
   // new events, so a set colliding with a clear leaves the bit set.
   always_comb begin
      riseEn_d  = riseEn_q;
      fallEn_d  = fallEn_q;
      clearMask = 32'h0;
      if (accept && isWrite) begin
         case (mem_addr[3:2])
            2'd1: riseEn_d  = (riseEn_q & ~laneMask) | (mem_wdata & laneMask);
            2'd2: fallEn_d  = (fallEn_q & ~laneMask) | (mem_wdata & laneMask);
            2'd3: clearMask = mem_wdata & laneMask;
            default: clearMask = 32'h0;
         endcase
      end
      status_d = (status_q & ~clearMask) | setEvents;
   end

   // Acknowledge and read-data capture. The acknowledge is a single-cycle
   // pulse after acceptance. Read data is captured at acceptance and held
   // until the next transfer. A write returns zero.
   always_comb begin
      rdy_d   = accept;
      rdata_d = rdata_q;
      if (accept) begin
         rdata_d = isWrite ? 32'h0 : regValue;
      end
   end

   // State registers. Reset wins over a transfer accepted on the same edge,
   // so that transfer is discarded and no acknowledge follows.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_q     <= 32'h0;
         s2_q     <= 32'h0;
         prev_q   <= 32'h0;
         riseEn_q <= 32'h0;
         fallEn_q <= 32'h0;
         status_q <= 32'h0;
         rdata_q  <= 32'h0;
         rdy_q    <= 1'b0;
      end else begin
         s1_q     <= pins;
         s2_q     <= s1_q;
         prev_q   <= s2_q;
         riseEn_q <= riseEn_d;
         fallEn_q <= fallEn_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
         rdy_q    <= rdy_d;
      end
   end

   // Outputs are gated by enable so several peripherals can share the bus
   // through a wire-OR. irq comes straight from the STATUS register.
   assign mem_ready = enable & rdy_q;
   assign mem_rdata = enable ? rdata_q : 32'h0;
   assign irq       = |status_q;

endmodule

// File: tb/tb_gpio_in.sv
// ---------------------------------------------------------------------------
// tb_gpio_in : self-checking bench for gpio_in.
//
// A behavioural model keeps a short history of the pin values seen at each
// clock edge and applies the register rules directly. When the model sees a
// transfer accepted, it pushes the expected read data into a queue. A
// monitor pops that queue whenever the DUT raises mem_ready and compares.
// The monitor also checks irq, mem_ready and the idle wire-OR value on
// every cycle.
//
// Ports: none. Clock and reset are generated locally.
// ---------------------------------------------------------------------------
module tb_gpio_in;

   logic        clk;
   logic        resetn;
   logic        enable;
   logic        mem_valid;
   logic        mem_instr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_addr;
   logic [31:0] pins;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        irq;

   int          compared;
   int          mismatched;
   bit          monOn;

   // Model state
   logic [31:0] mRise;
   logic [31:0] mFall;
   logic [31:0] mStatus;
   bit          mRdy;
   logic [31:0] hist [3];
   logic [31:0] expQ [$];
   logic [31:0] mNow;
   logic [31:0] mOld;
   logic [31:0] mEv;
   logic [31:0] mMask;
   logic [31:0] mClr;
   bit          mAcc;
   logic [31:0] popVal;

   gpio_in dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_instr (mem_instr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .pins      (pins),
      .irq       (irq)
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] byteLanes(input logic [3:0] strb);
      logic [31:0] m;
      m = 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) m[8*b +: 8] = 8'hFF;
      end
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One bus transfer. It is entered just after a rising edge and holds the
   // request for one edge, which is the acceptance edge. It then waits out
   // the acknowledge cycle so the next call can be accepted at once.
   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] strb,
                                input logic [31:0] wdata);
      enable    = 1'b1;
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wstrb = strb;
      mem_wdata = wdata;
      mem_instr = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      @(posedge clk); #2;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic readAll();
      for (int r = 0; r < 4; r++) applyStimulus(32'(r * 4), 4'h0, 32'h0);
   endtask

   // Reference model, evaluated at every rising edge from the inputs the
   // bench is driving. A pin value that is present at edge k is visible as
   // DATA two edges later. An edge is therefore judged from the pin values
   // seen two and three edges ago.
   always @(posedge clk) begin
      if (!resetn) begin
         mRise   = 32'h0;
         mFall   = 32'h0;
         mStatus = 32'h0;
         mRdy    = 1'b0;
         hist[0] = 32'h0;
         hist[1] = 32'h0;
         hist[2] = 32'h0;
         expQ.delete();
      end else begin
         mNow = hist[1];
         mOld = hist[2];
         mEv  = (mNow & ~mOld & mRise) | (~mNow & mOld & mFall);
         mAcc = mem_valid && enable && !mRdy;
         mClr = 32'h0;
         if (mAcc) begin
            mMask = byteLanes(mem_wstrb);
            if (mem_wstrb == 4'h0) begin
               case (mem_addr[3:2])
                  2'd0: expQ.push_back(mNow);
                  2'd1: expQ.push_back(mRise);
                  2'd2: expQ.push_back(mFall);
                  default: expQ.push_back(mStatus);
               endcase
            end else begin
               expQ.push_back(32'h0);
               if (mem_addr[3:2] == 2'd1) mRise = (mRise & ~mMask) | (mem_wdata & mMask);
               if (mem_addr[3:2] == 2'd2) mFall = (mFall & ~mMask) | (mem_wdata & mMask);
               if (mem_addr[3:2] == 2'd3) mClr  = mem_wdata & mMask;
            end
         end
         mStatus = (mStatus & ~mClr) | mEv;
         mRdy    = mAcc;
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = pins;
      end
   end

   // Monitor on the falling edge. It checks irq and the acknowledge every
   // cycle, the zero wire-OR value when the block is not selected, and the
   // read data against the scoreboard whenever mem_ready is seen.
   always @(negedge clk) begin
      if (monOn) begin
         checkOutput("irq", {31'h0, irq}, {31'h0, |mStatus});
         checkOutput("mem_ready", {31'h0, mem_ready}, {31'h0, mRdy & enable});
         if (!enable) checkOutput("rdata_idle", mem_rdata, 32'h0);
         if (mem_ready) begin
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL ready_unexpected: got ready=1, expected no pending transfer");
            end else begin
               popVal = expQ.pop_front();
               checkOutput("rdata", mem_rdata, popVal);
            end
         end
      end
   end

   // Directed scenarios first, then a randomized phase, then reset during a
   // transfer. The bench finishes with the summary line.
   initial begin
      compared   = 0;
      mismatched = 0;
      monOn      = 1'b0;
      resetn     = 1'b0;
      enable     = 1'b0;
      mem_valid  = 1'b0;
      mem_instr  = 1'b0;
      mem_wstrb  = 4'h0;
      mem_wdata  = 32'h0;
      mem_addr   = 32'h0;
      pins       = 32'h0;
      repeat (3) @(posedge clk);
      #2;
      resetn = 1'b1;
      monOn  = 1'b1;

      // Reset state as seen on the selected bus
      enable = 1'b1;
      @(negedge clk);
      checkOutput("reset_ready", {31'h0, mem_ready}, 32'h0);
      checkOutput("reset_rdata", mem_rdata, 32'h0);
      checkOutput("reset_irq", {31'h0, irq}, 32'h0);
      @(posedge clk); #2;
      readAll();

      // All pins high right after reset must not raise STATUS
      pins = 32'hFFFF_FFFF;
      waitCycles(4);
      applyStimulus(32'hC, 4'h0, 32'h0);

      // DATA read path
      pins = 32'hA5A5_0F0F;
      waitCycles(3);
      applyStimulus(32'h0, 4'h0, 32'h0);

      // Rising edge on pin 0 only
      pins = 32'h0;
      waitCycles(3);
      applyStimulus(32'h4, 4'hF, 32'h0000_0001);
      pins = 32'h0000_0003;
      waitCycles(4);
      pins = 32'h0000_0001;
      waitCycles(4);
      applyStimulus(32'hC, 4'h0, 32'h0);

      // Build STATUS = 3, clear bit 0, then collide a clear with a fall
      applyStimulus(32'h4, 4'hF, 32'h0000_0003);
      pins = 32'h0000_0003;
      waitCycles(4);
      applyStimulus(32'hC, 4'h0, 32'h0);
      applyStimulus(32'hC, 4'h1, 32'h0000_0001);
      applyStimulus(32'hC, 4'h0, 32'h0);
      applyStimulus(32'h8, 4'hF, 32'h0000_0002);
      pins = 32'h0000_0001;
      waitCycles(2);
      applyStimulus(32'hC, 4'h1, 32'h0000_0002);
      applyStimulus(32'hC, 4'h0, 32'h0);

      // Byte-lane writes and an ignored DATA write
      applyStimulus(32'h8, 4'hF, 32'h0);
      applyStimulus(32'h8, 4'b0100, 32'hFFFF_FFFF);
      applyStimulus(32'h8, 4'h0, 32'h0);
      applyStimulus(32'h0, 4'hF, 32'h1234_5678);
      applyStimulus(32'h0, 4'h0, 32'h0);

      // Requests without the select must do nothing
      enable    = 1'b0;
      mem_valid = 1'b1;
      mem_addr  = 32'hC;
      mem_wstrb = 4'hF;
      mem_wdata = 32'hFFFF_FFFF;
      waitCycles(5);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      readAll();

      // Randomized traffic with wandering pins
      for (int i = 0; i < 150; i++) begin
         pins = pins ^ ($urandom & $urandom & $urandom);
         if ($urandom_range(0, 2) == 0) begin
            enable    = 1'($urandom_range(0, 1));
            mem_valid = 1'b0;
            waitCycles($urandom_range(1, 3));
         end
         applyStimulus($urandom,
                       ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      end

      // Make sure STATUS is non-zero, then reset on a STATUS write
      applyStimulus(32'h4, 4'hF, 32'hFFFF_FFFF);
      pins = ~pins;
      waitCycles(4);
      enable    = 1'b1;
      mem_valid = 1'b1;
      mem_addr  = 32'hC;
      mem_wstrb = 4'hF;
      mem_wdata = 32'h0;
      resetn    = 1'b0;
      @(posedge clk); #2;
      resetn    = 1'b1;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      @(negedge clk);
      checkOutput("abort_irq", {31'h0, irq}, 32'h0);
      checkOutput("abort_rdata", mem_rdata, 32'h0);
      @(posedge clk); #2;
      readAll();

      waitCycles(3);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
